// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared state encoding, opcode/op fields and datapath select codes
//            for the CPU controller.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int WORD_W = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_WAIT      = 3'd0;
    localparam state_t ST_DECODE    = 3'd1;
    localparam state_t ST_WRITE_IMM = 3'd2;
    localparam state_t ST_GET_A     = 3'd3;
    localparam state_t ST_GET_B     = 3'd4;
    localparam state_t ST_ALU       = 3'd5;
    localparam state_t ST_WRITE_REG = 3'd6;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // op field meaning depends on opcode: MOV uses IMM/REG, ALU uses the rest
    localparam logic [1:0] OP_IMM = 2'b10;
    localparam logic [1:0] OP_REG = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MVN = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam logic VSEL_IMM = 1'b1;
    localparam logic VSEL_C   = 1'b0;

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_decoder
// Purpose  : Splits the instruction register into its fields and produces the
//            sign-extended 8-bit and 5-bit immediates.
// Revision : 1.0 - initial release
// ============================================================================
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [WORD_W-1:0] i_ir,
    output logic [2:0]        o_opcode,
    output logic [1:0]        o_op,
    output logic [2:0]        o_rn,
    output logic [2:0]        o_rd,
    output logic [1:0]        o_sh,
    output logic [2:0]        o_rm,
    output logic [WORD_W-1:0] o_sximm8,
    output logic [WORD_W-1:0] o_sximm5
);

    assign o_opcode = i_ir[15:13];
    assign o_op     = i_ir[12:11];
    assign o_rn     = i_ir[10:8];
    assign o_rd     = i_ir[7:5];
    assign o_sh     = i_ir[4:3];
    assign o_rm     = i_ir[2:0];

    assign o_sximm8 = {{8{i_ir[7]}}, i_ir[7:0]};
    assign o_sximm5 = {{11{i_ir[4]}}, i_ir[4:0]};

endmodule
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : cpu_controller
// Purpose  : Instruction register and Moore control FSM that sequences the
//            datapath control inputs one state per clock.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_controller
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] in,
    input  logic              load,
    input  logic              s,
    output logic              w,
    output logic [WORD_W-1:0] datapath_in,
    output logic [WORD_W-1:0] aselin,
    output logic [WORD_W-1:0] bselin,
    output logic              vsel,
    output logic [2:0]        writenum,
    output logic [2:0]        readnum,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop
);

    state_t            r_state;
    state_t            w_next_state;
    logic [WORD_W-1:0] r_ir;

    logic [2:0] w_opcode;
    logic [1:0] w_op;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [1:0] w_sh;
    logic [2:0] w_rm;

    logic w_is_mov_imm;
    logic w_is_mov_reg;
    logic w_is_alu;
    logic w_is_cmp;
    logic w_is_mvn;

    instr_decoder u_decoder (
        .i_ir     (r_ir),
        .o_opcode (w_opcode),
        .o_op     (w_op),
        .o_rn     (w_rn),
        .o_rd     (w_rd),
        .o_sh     (w_sh),
        .o_rm     (w_rm),
        .o_sximm8 (datapath_in),
        .o_sximm5 (bselin)
    );

    assign aselin = '0;

    assign w_is_mov_imm = (w_opcode == OPC_MOV) && (w_op == OP_IMM);
    assign w_is_mov_reg = (w_opcode == OPC_MOV) && (w_op == OP_REG);
    assign w_is_alu     = (w_opcode == OPC_ALU);
    assign w_is_cmp     = w_is_alu && (w_op == OP_CMP);
    assign w_is_mvn     = w_is_alu && (w_op == OP_MVN);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_WAIT;
            r_ir    <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ST_WAIT) && load) begin
                r_ir <= in;
            end
        end
    end

    always_comb begin
        w_next_state = ST_WAIT;
        w            = 1'b0;
        vsel         = VSEL_C;
        writenum     = 3'd0;
        readnum      = 3'd0;
        write        = 1'b0;
        loada        = 1'b0;
        loadb        = 1'b0;
        loadc        = 1'b0;
        loads        = 1'b0;
        asel         = 1'b0;
        bsel         = 1'b0;
        shift        = 2'b00;
        ALUop        = ALU_ADD;

        case (r_state)
            ST_WAIT: begin
                w            = 1'b1;
                w_next_state = s ? ST_DECODE : ST_WAIT;
            end
            ST_DECODE: begin
                // Anything not matched here is illegal and falls back to WAIT
                if (w_is_mov_imm)                 w_next_state = ST_WRITE_IMM;
                else if (w_is_mov_reg || w_is_mvn) w_next_state = ST_GET_B;
                else if (w_is_alu)                 w_next_state = ST_GET_A;
                else                               w_next_state = ST_WAIT;
            end
            ST_WRITE_IMM: begin
                writenum     = w_rn;
                vsel         = VSEL_IMM;
                write        = 1'b1;
                w_next_state = ST_WAIT;
            end
            ST_GET_A: begin
                readnum      = w_rn;
                loada        = 1'b1;
                w_next_state = ST_GET_B;
            end
            ST_GET_B: begin
                readnum      = w_rm;
                loadb        = 1'b1;
                w_next_state = ST_ALU;
            end
            ST_ALU: begin
                shift        = w_sh;
                loadc        = 1'b1;
                asel         = w_is_mov_reg;
                ALUop        = w_is_mov_reg ? ALU_ADD : w_op;
                loads        = w_is_cmp;
                w_next_state = w_is_cmp ? ST_WAIT : ST_WRITE_REG;
            end
            ST_WRITE_REG: begin
                writenum     = w_rd;
                vsel         = VSEL_C;
                write        = 1'b1;
                w_next_state = ST_WAIT;
            end
            default: w_next_state = ST_WAIT;
        endcase

        // Keep datapath registers from committing on the reset edge
        if (!reset_n) begin
            write = 1'b0;
            loada = 1'b0;
            loadb = 1'b0;
            loadc = 1'b0;
            loads = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_controller
// Purpose  : Drives cpu_controller with directed and random instructions and
//            checks it against an instruction-level register-file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in = 16'h0000;
    logic        load = 1'b0;
    logic        s = 1'b0;
    logic        w;
    logic [15:0] datapath_in, aselin, bselin;
    logic        vsel, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  writenum, readnum;
    logic [1:0]  shift, ALUop;

    cpu_controller u_dut (
        .clk(clk), .reset_n(reset_n), .in(in), .load(load), .s(s), .w(w),
        .datapath_in(datapath_in), .aselin(aselin), .bselin(bselin),
        .vsel(vsel), .writenum(writenum), .readnum(readnum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       write, loada, loadb, loadc, loads, asel, bsel, vsel;
        logic [1:0] shift, aluop;
        logic [2:0] readnum, writenum;
    } ctl_t;

    int          checks = 0;
    int          errors = 0;
    ctl_t        trace[$];
    int          n_write;
    logic [15:0] wr_din;
    int          inject_at = -1;

    // Datapath emulation driven by the controller outputs
    logic [15:0] dp_regs[8];
    logic [15:0] dp_a, dp_b, dp_c;
    logic        dp_z;

    // Instruction-level reference state
    logic [15:0] ref_regs[8];
    logic [15:0] ref_c;
    logic        ref_z;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] shift16(input logic [15:0] b, input logic [1:0] sh);
        case (sh)
            2'd0:    return b;
            2'd1:    return b << 1;
            2'd2:    return b >> 1;
            default: return {b[15], b[15:1]};
        endcase
    endfunction

    task automatic clk_cycle();
        ctl_t        c;
        logic [15:0] ain, bin, alu, rdat, wdat;
        #1;
        c = {write, loada, loadb, loadc, loads, asel, bsel, vsel,
             shift, ALUop, readnum, writenum};
        if ((write | loada | loadb | loadc | loads) === 1'b1) trace.push_back(c);
        if (write === 1'b1) begin
            n_write++;
            wr_din = datapath_in;
        end
        ain = asel ? aselin : dp_a;
        bin = bsel ? bselin : shift16(dp_b, shift);
        case (ALUop)
            2'd0:    alu = ain + bin;
            2'd1:    alu = ain - bin;
            2'd2:    alu = ain & bin;
            default: alu = ~bin;
        endcase
        rdat = dp_regs[c.readnum];
        wdat = vsel ? datapath_in : dp_c;
        @(posedge clk);
        if (c.write) dp_regs[c.writenum] = wdat;
        if (c.loada) dp_a = rdat;
        if (c.loadb) dp_b = rdat;
        if (c.loadc) dp_c = alu;
        if (c.loads) dp_z = (alu == 16'h0000);
        #1;
    endtask

    task automatic isa_exec(input logic [15:0] ir, output int lat, output int nwr);
        logic [2:0]  opc, rn, rd, rm;
        logic [1:0]  op, sh;
        logic [15:0] b;
        opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8];
        rd  = ir[7:5];   sh = ir[4:3];   rm = ir[2:0];
        b   = shift16(ref_regs[rm], sh);
        lat = 1; nwr = 0;
        if (opc == 3'b110 && op == 2'b10) begin
            ref_regs[rn] = {{8{ir[7]}}, ir[7:0]}; lat = 2; nwr = 1;
        end else if (opc == 3'b110 && op == 2'b00) begin
            ref_c = b; ref_regs[rd] = b; lat = 4; nwr = 1;
        end else if (opc == 3'b101) begin
            case (op)
                2'd0: begin ref_c = ref_regs[rn] + b; ref_regs[rd] = ref_c; lat = 5; nwr = 1; end
                2'd1: begin ref_c = ref_regs[rn] - b; ref_z = (ref_c == 16'h0000); lat = 4; end
                2'd2: begin ref_c = ref_regs[rn] & b; ref_regs[rd] = ref_c; lat = 5; nwr = 1; end
                default: begin ref_c = ~b; ref_regs[rd] = ref_c; lat = 4; nwr = 1; end
            endcase
        end
    endtask

    task automatic cmp_state(input string tag);
        for (int i = 0; i < 8; i++) chk($sformatf("%s.R%0d", tag, i), dp_regs[i], ref_regs[i]);
        chk({tag, ".C"}, dp_c, ref_c);
        chk({tag, ".Z"}, dp_z, ref_z);
    endtask

    task automatic run_instr(input logic [15:0] ir, input bit sep, input string tag);
        int lat, exp_lat, exp_nwr;
        trace.delete();
        n_write = 0;
        in = ir;
        if (sep) begin
            load = 1'b1; clk_cycle(); load = 1'b0;
        end
        s = 1'b1; load = !sep;
        clk_cycle();
        s = 1'b0; load = 1'b0;
        lat = 0;
        do begin
            if (lat == inject_at) begin in = 16'hD555; load = 1'b1; end
            else load = 1'b0;
            clk_cycle();
            lat++;
        end while (w !== 1'b1 && lat < 20);
        load = 1'b0;
        isa_exec(ir, exp_lat, exp_nwr);
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".writes"}, n_write, exp_nwr);
        cmp_state(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ir;
        logic [2:0]  bad_opc;
        for (int i = 0; i < 8; i++) begin dp_regs[i] = '0; ref_regs[i] = '0; end
        dp_a = '0; dp_b = '0; dp_c = '0; dp_z = 1'b0;
        ref_c = '0; ref_z = 1'b0;

        // Reset with start and load both active: reset must win
        reset_n = 1'b0; s = 1'b1; load = 1'b1; in = 16'($urandom);
        clk_cycle();
        clk_cycle();
        chk("rst.w", w, 1'b1);
        chk("rst.enables", {write, loada, loadb, loadc, loads}, 5'b0);
        chk("rst.selects", {vsel, asel, bsel, shift, ALUop}, 7'b0);
        chk("rst.nums", {readnum, writenum}, 6'b0);
        chk("rst.datapath_in", datapath_in, 16'h0000);
        chk("rst.bselin", bselin, 16'h0000);
        chk("rst.aselin", aselin, 16'h0000);
        reset_n = 1'b1; s = 1'b0; load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk_cycle();
            chk("idle.w", w, 1'b1);
        end

        run_instr(16'hD007, 1'b1, "mov_r0_7");
        chk("mov_r0_7.trace_len", trace.size(), 1);
        if (trace.size() == 1) begin
            chk("mov_r0_7.writenum", trace[0].writenum, 3'd0);
            chk("mov_r0_7.vsel", trace[0].vsel, 1'b1);
        end
        chk("mov_r0_7.din", wr_din, 16'h0007);

        run_instr(16'hD102, 1'b0, "mov_r1_2");

        run_instr(16'hA148, 1'b0, "add_r2");
        chk("add_r2.trace_len", trace.size(), 4);
        if (trace.size() == 4) begin
            chk("add_r2.geta", {trace[0].readnum, trace[0].loada, trace[0].loadb}, {3'd1, 2'b10});
            chk("add_r2.getb", {trace[1].readnum, trace[1].loada, trace[1].loadb}, {3'd0, 2'b01});
            chk("add_r2.alu", {trace[2].shift, trace[2].aluop, trace[2].loadc, trace[2].asel,
                               trace[2].bsel, trace[2].loads}, {2'b01, 2'b00, 4'b1000});
            chk("add_r2.wr", {trace[3].writenum, trace[3].write, trace[3].vsel}, {3'd2, 2'b10});
        end
        chk("add_r2.R2", dp_regs[2], 16'd16);
        chk("add_r2.datapath_out", dp_c, 16'h0010);

        run_instr(16'hA900, 1'b0, "cmp_r1_r0");
        chk("cmp.trace_len", trace.size(), 3);
        if (trace.size() == 3)
            chk("cmp.alu", {trace[2].loads, trace[2].aluop}, {1'b1, 2'b01});

        run_instr(16'hD3F0, 1'b1, "mov_neg");
        chk("mov_neg.din", wr_din, 16'hFFF0);
        chk("mov_neg.R3", dp_regs[3], 16'hFFF0);

        run_instr(16'hE000, 1'b0, "illegal");
        chk("illegal.trace_len", trace.size(), 0);

        inject_at = 1;
        run_instr(16'hA148, 1'b0, "add_midload");
        inject_at = -1;
        chk("add_midload.ir_kept", datapath_in, 16'h0048);

        // Abandon an ADD in GET_B
        in = 16'hA148; load = 1'b1; s = 1'b1;
        clk_cycle();
        load = 1'b0; s = 1'b0;
        clk_cycle();
        clk_cycle();
        chk("abort.in_getb", loadb, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("abort.forced", {write, loada, loadb, loadc, loads}, 5'b0);
        n_write = 0;
        clk_cycle();
        reset_n = 1'b1;
        chk("abort.w", w, 1'b1);
        chk("abort.writes", n_write, 0);
        chk("abort.ir_cleared", datapath_in, 16'h0000);
        cmp_state("abort");

        for (int k = 0; k < 40; k++) begin
            ir = 16'($urandom);
            case ($urandom_range(0, 6))
                0: ir[15:11] = 5'b11010;
                1: ir[15:11] = 5'b11000;
                2: ir[15:11] = 5'b10100;
                3: ir[15:11] = 5'b10101;
                4: ir[15:11] = 5'b10110;
                5: ir[15:11] = 5'b10111;
                default: begin
                    bad_opc = 3'($urandom_range(0, 5));
                    if (bad_opc == 3'd5) bad_opc = 3'd7;
                    ir[15:13] = bad_opc;
                end
            endcase
            run_instr(ir, 1'($urandom_range(0, 1)), $sformatf("rand%0d_%h", k, ir));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
